// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I/RVC types, opcode enum and instruction encoders.
package rv32i_types;
  typedef logic [15:0] rv32i_half;
  localparam logic [31:0] RVC_ILLEGAL = 32'h0000_0000;
  typedef enum logic [4:0] {
    C0_ADDI4SPN = 5'b000_00,
    C0_LW = 5'b010_00,
    C0_SW = 5'b110_00,
    C1_ADDI = 5'b000_01,
    C1_JAL = 5'b001_01,
    C1_LI = 5'b010_01,
    C1_LUI = 5'b011_01,
    C1_MISC = 5'b100_01,
    C1_J = 5'b101_01,
    C1_BEQZ = 5'b110_01,
    C1_BNEZ = 5'b111_01,
    C2_SLLI = 5'b000_10,
    C2_LWSP = 5'b010_10,
    C2_JR_MV_ADD = 5'b100_10,
    C2_SWSP = 5'b110_10
  } rv32ic_opcode;
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd, logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction
endpackage

// File: rtl/rvc_expander.sv
// rvc_expander: combinational RV32C to RV32I expansion; reserved/illegal encodings give RVC_ILLEGAL.
module rvc_expander
  import rv32i_types::*;
(
  input  logic [15:0] i_c,
  output logic [31:0] o_ir
);
  rv32ic_opcode w_op;
  logic [4:0] w_rd, w_rs2, w_rs1p, w_rs2p;
  logic [11:0] w_imm6, w_imm16sp, w_lw_off;
  logic [9:0] w_nzuimm;
  logic [12:1] w_bimm;
  logic [20:1] w_jimm;
  logic [2:0] w_alu_f3;
  assign w_op = rv32ic_opcode'({i_c[15:13], i_c[1:0]});
  assign w_rd = i_c[11:7];
  assign w_rs2 = i_c[6:2];
  assign w_rs1p = {2'b01, i_c[9:7]};
  assign w_rs2p = {2'b01, i_c[4:2]};
  assign w_imm6 = {{6{i_c[12]}}, i_c[12], i_c[6:2]};
  assign w_imm16sp = {{2{i_c[12]}}, i_c[12], i_c[4:3], i_c[5], i_c[2], i_c[6], 4'b0};
  assign w_lw_off = {5'b0, i_c[5], i_c[12:10], i_c[6], 2'b00};
  assign w_nzuimm = {i_c[10:7], i_c[12:11], i_c[5], i_c[6], 2'b00};
  assign w_bimm = {{5{i_c[12]}}, i_c[6:5], i_c[2], i_c[11:10], i_c[4:3]};
  assign w_jimm = {{10{i_c[12]}}, i_c[8], i_c[10:9], i_c[6], i_c[7], i_c[2], i_c[11], i_c[5:3]};
  assign w_alu_f3 = i_c[6:5] == 2'b00 ? 3'b000 : i_c[6:5] == 2'b01 ? 3'b100 :
                    i_c[6:5] == 2'b10 ? 3'b110 : 3'b111;
  always_comb begin
    o_ir = RVC_ILLEGAL;
    case (w_op)
      C0_ADDI4SPN: if (w_nzuimm != 10'd0) o_ir = enc_i({2'b0, w_nzuimm}, 5'd2, 3'b000, w_rs2p, 7'h13);
      C0_LW: o_ir = enc_i(w_lw_off, w_rs1p, 3'b010, w_rs2p, 7'h03);
      C0_SW: o_ir = enc_s(w_lw_off, w_rs2p, w_rs1p, 3'b010, 7'h23);
      C1_ADDI: o_ir = enc_i(w_imm6, w_rd, 3'b000, w_rd, 7'h13);
      C1_JAL: o_ir = enc_j(w_jimm, 5'd1, 7'h6f);
      C1_LI: o_ir = enc_i(w_imm6, 5'd0, 3'b000, w_rd, 7'h13);
      C1_LUI: begin
        if (w_rd == 5'd2) begin
          if (w_imm16sp != 12'd0) o_ir = enc_i(w_imm16sp, 5'd2, 3'b000, 5'd2, 7'h13);
        end else if ({i_c[12], i_c[6:2]} != 6'd0) begin
          o_ir = enc_u({{14{i_c[12]}}, i_c[12], i_c[6:2]}, w_rd, 7'h37);
        end
      end
      C1_MISC: begin
        case (i_c[11:10])
          2'b00: if (!i_c[12]) o_ir = enc_i({7'b0, i_c[6:2]}, w_rs1p, 3'b101, w_rs1p, 7'h13);
          2'b01: if (!i_c[12]) o_ir = enc_i({7'b0100000, i_c[6:2]}, w_rs1p, 3'b101, w_rs1p, 7'h13);
          2'b10: o_ir = enc_i(w_imm6, w_rs1p, 3'b111, w_rs1p, 7'h13);
          default: if (!i_c[12]) o_ir = enc_r(i_c[6:5] == 2'b00 ? 7'h20 : 7'h00, w_rs2p, w_rs1p,
                                              w_alu_f3, w_rs1p, 7'h33);
        endcase
      end
      C1_J: o_ir = enc_j(w_jimm, 5'd0, 7'h6f);
      C1_BEQZ: o_ir = enc_b(w_bimm, 5'd0, w_rs1p, 3'b000, 7'h63);
      C1_BNEZ: o_ir = enc_b(w_bimm, 5'd0, w_rs1p, 3'b001, 7'h63);
      C2_SLLI: if (!i_c[12]) o_ir = enc_i({7'b0, i_c[6:2]}, w_rd, 3'b001, w_rd, 7'h13);
      C2_LWSP: if (w_rd != 5'd0) o_ir = enc_i({4'b0, i_c[3:2], i_c[12], i_c[6:4], 2'b00}, 5'd2, 3'b010, w_rd, 7'h03);
      C2_JR_MV_ADD: begin
        if (!i_c[12])
          o_ir = w_rs2 != 5'd0 ? enc_r(7'h00, w_rs2, 5'd0, 3'b000, w_rd, 7'h33) :
                 w_rd != 5'd0 ? enc_i(12'd0, w_rd, 3'b000, 5'd0, 7'h67) : RVC_ILLEGAL;
        else
          o_ir = w_rs2 != 5'd0 ? enc_r(7'h00, w_rs2, w_rd, 3'b000, w_rd, 7'h33) :
                 w_rd != 5'd0 ? enc_i(12'd0, w_rd, 3'b000, 5'd1, 7'h67) : 32'h0010_0073;
      end
      C2_SWSP: o_ir = enc_s({4'b0, i_c[8:7], i_c[12:9], 2'b00}, w_rs2, 5'd2, 3'b010, 7'h23);
      default: o_ir = RVC_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: word-to-instruction aligner with redirect flush; define RVC_EXPAND_EN to
// expand compressed instructions to RV32I via rvc_expander, otherwise they are output raw.
module fetch_aligner
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fw_valid,
  output logic        fw_ready,
  input  logic [31:0] fw_addr,
  input  logic [31:0] fw_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_compressed
);
  // Halfword i lives in r_buf[16*i +: 16]; halfwords at or above r_cnt are kept zero.
  logic [63:0] r_buf;
  logic [2:0]  r_cnt;
  logic [31:0] r_head_pc;
  logic [29:0] r_expect;
  logic        r_skip_lo;
  rv32i_half   w_h0;
  logic        w_is32, w_fire, w_acc, w_unused;
  logic [1:0]  w_cons, w_app;
  logic [2:0]  w_sh_cnt;
  logic [63:0] w_app_data, w_nbuf;
  logic [31:0] w_c_ir;
  assign w_h0 = r_buf[15:0];
  assign w_is32 = w_h0[1:0] == 2'b11;
  assign ir_valid = w_is32 ? r_cnt >= 3'd2 : r_cnt != 3'd0;
  assign ir_compressed = r_cnt != 3'd0 && !w_is32;
  assign ir_pc = r_head_pc;
  assign ir = r_cnt == 3'd0 ? 32'h0 : w_is32 ? r_buf[31:0] : w_c_ir;
`ifdef RVC_EXPAND_EN
  rvc_expander u_rvc (.i_c(w_h0), .o_ir(w_c_ir));
`else
  assign w_c_ir = {16'h0, w_h0};
`endif
  assign fw_ready = !rst && !redirect && r_cnt <= 3'd2;
  assign w_fire = ir_valid && ir_ready;
  assign w_acc = fw_valid && fw_ready && fw_addr[31:2] == r_expect;
  assign w_cons = !w_fire ? 2'd0 : w_is32 ? 2'd2 : 2'd1;
  assign w_app = !w_acc ? 2'd0 : r_skip_lo ? 2'd1 : 2'd2;
  assign w_sh_cnt = r_cnt - {1'b0, w_cons};
  assign w_app_data = !w_acc ? 64'h0 : r_skip_lo ? {48'h0, fw_data[31:16]} : {32'h0, fw_data};
  // Consume from the bottom first, then append above what remains.
  assign w_nbuf = (r_buf >> {w_cons, 4'b0}) | (w_app_data << {w_sh_cnt, 4'b0});
  assign w_unused = ^{fw_addr[1:0], redirect_pc[0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= 64'h0;
      r_cnt <= 3'd0;
      r_head_pc <= RESET_PC;
      r_expect <= RESET_PC[31:2];
      r_skip_lo <= RESET_PC[1];
    end else if (redirect) begin
      r_buf <= 64'h0;
      r_cnt <= 3'd0;
      r_head_pc <= {redirect_pc[31:1], 1'b0};
      r_expect <= redirect_pc[31:2];
      r_skip_lo <= redirect_pc[1];
    end else begin
      r_buf <= w_nbuf;
      r_cnt <= w_sh_cnt + {1'b0, w_app};
      if (w_fire) r_head_pc <= r_head_pc + (w_is32 ? 32'd4 : 32'd2);
      if (w_acc) begin
        r_expect <= r_expect + 30'd1;
        r_skip_lo <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: directed self-checking bench for fetch_aligner (honours RVC_EXPAND_EN).
module tb_fetch_aligner;
  logic        clk = 1'b0;
  logic        rst, fw_valid, fw_ready, redirect, ir_valid, ir_ready, ir_compressed;
  logic [31:0] fw_addr, fw_data, redirect_pc, ir, ir_pc;
  int n_checks = 0;
  int n_fail = 0;
  int nxt;
`ifdef RVC_EXPAND_EN
  localparam logic [31:0] E_4505 = 32'h0010_0513;
  localparam logic [31:0] E_0085 = 32'h0010_8093;
  localparam logic [31:0] E_4515 = 32'h0050_0513;
`else
  localparam logic [31:0] E_4505 = 32'h0000_4505;
  localparam logic [31:0] E_0085 = 32'h0000_0085;
  localparam logic [31:0] E_4515 = 32'h0000_4515;
`endif
  fetch_aligner dut (
    .clk(clk), .rst(rst), .fw_valid(fw_valid), .fw_ready(fw_ready), .fw_addr(fw_addr),
    .fw_data(fw_data), .redirect(redirect), .redirect_pc(redirect_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc), .ir_compressed(ir_compressed)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    fw_valid = 1'b0;
    redirect = 1'b0;
    ir_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask
  function automatic logic [31:0] wrd(int k);
    return 32'h0000_0013 | (32'(k) << 20);
  endfunction
  initial begin
    rst = 1'b1; fw_valid = 1'b0; fw_addr = '0; fw_data = '0;
    redirect = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
    tick(); tick();
    check("rst_fw_ready", 32'(fw_ready), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_pc", ir_pc, 32'h60);
    check("rst_ir_c", 32'(ir_compressed), 32'd0);
    rst = 1'b0; #1;
    check("idle_fw_ready", 32'(fw_ready), 32'd1);
    // plain 32-bit instruction
    fw_valid = 1'b1; fw_addr = 32'h60; fw_data = 32'h00A0_0093;
    tick(); fw_valid = 1'b0; #1;
    check("w32_valid", 32'(ir_valid), 32'd1);
    check("w32_ir", ir, 32'h00A0_0093);
    check("w32_pc", ir_pc, 32'h60);
    check("w32_c", 32'(ir_compressed), 32'd0);
    ir_ready = 1'b1; tick(); ir_ready = 1'b0; #1;
    check("w32_drained", 32'(ir_valid), 32'd0);
    check("w32_next_pc", ir_pc, 32'h64);
    // two compressed in one word
    do_reset();
    fw_valid = 1'b1; fw_addr = 32'h60; fw_data = 32'h0085_4505;
    tick(); fw_valid = 1'b0; #1;
    check("c2_a_valid", 32'(ir_valid), 32'd1);
    check("c2_a_ir", ir, E_4505);
    check("c2_a_pc", ir_pc, 32'h60);
    check("c2_a_c", 32'(ir_compressed), 32'd1);
    ir_ready = 1'b1; tick();
    check("c2_b_valid", 32'(ir_valid), 32'd1);
    check("c2_b_ir", ir, E_0085);
    check("c2_b_pc", ir_pc, 32'h62);
    tick();
    check("c2_empty", 32'(ir_valid), 32'd0);
    check("c2_head_pc", ir_pc, 32'h64);
    ir_ready = 1'b0;
    // 32-bit instruction straddling a word boundary
    do_reset();
    ir_ready = 1'b1;
    fw_valid = 1'b1; fw_addr = 32'h60; fw_data = 32'h0513_4505;
    tick(); fw_valid = 1'b0; #1;
    check("st_c_ir", ir, E_4505);
    check("st_c_pc", ir_pc, 32'h60);
    tick();
    check("st_wait_valid", 32'(ir_valid), 32'd0);
    check("st_wait_pc", ir_pc, 32'h62);
    fw_valid = 1'b1; fw_addr = 32'h64; fw_data = 32'h1234_00A0;
    tick(); fw_valid = 1'b0; #1;
    check("st_valid", 32'(ir_valid), 32'd1);
    check("st_ir", ir, 32'h00A0_0513);
    check("st_pc", ir_pc, 32'h62);
    check("st_c", 32'(ir_compressed), 32'd0);
    tick();
    check("st_after_pc", ir_pc, 32'h66);
    check("st_after_c", 32'(ir_compressed), 32'd1);
    ir_ready = 1'b0;
    // redirect with a stale word in flight; bit 0 of redirect_pc ignored
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h103;
    fw_valid = 1'b1; fw_addr = 32'h70; fw_data = 32'hDEAD_BEEF; #1;
    check("rd_fw_ready", 32'(fw_ready), 32'd0);
    tick(); redirect = 1'b0; #1;
    check("rd_valid", 32'(ir_valid), 32'd0);
    check("rd_pc", ir_pc, 32'h102);
    check("rd_fw_ready_after", 32'(fw_ready), 32'd1);
    tick();
    fw_addr = 32'h100; fw_data = 32'h4515_FFFF; #1;
    check("rd_stale_dropped", 32'(ir_valid), 32'd0);
    tick(); fw_valid = 1'b0; #1;
    check("rd_hi_valid", 32'(ir_valid), 32'd1);
    check("rd_hi_ir", ir, E_4515);
    check("rd_hi_pc", ir_pc, 32'h102);
    check("rd_hi_c", 32'(ir_compressed), 32'd1);
    // all-zero halfword is illegal: raw or expanded it reads as zero
    do_reset();
    fw_valid = 1'b1; fw_addr = 32'h60; fw_data = 32'h0001_0000;
    tick(); fw_valid = 1'b0; #1;
    check("zero_valid", 32'(ir_valid), 32'd1);
    check("zero_ir", ir, 32'h0);
    check("zero_c", 32'(ir_compressed), 32'd1);
    // backpressure: two words fill the buffer, then fw_ready drops
    do_reset();
    nxt = 0;
    for (int i = 0; i < 5; i++) begin
      fw_valid = 1'b1; fw_addr = 32'h60 + 32'(4 * nxt); fw_data = wrd(nxt); #1;
      check("bp_fw_ready", 32'(fw_ready), 32'(i < 2));
      tick();
      if (i < 2) nxt++;
      check("bp_ir_stable", ir, wrd(0));
      check("bp_pc_stable", ir_pc, 32'h60);
    end
    ir_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      fw_addr = 32'h60 + 32'(4 * nxt); fw_data = wrd(nxt); #1;
      check("rel_fw_ready", 32'(fw_ready), 32'(r != 0));
      check("rel_valid", 32'(ir_valid), 32'd1);
      check("rel_ir", ir, wrd(r));
      check("rel_pc", ir_pc, 32'h60 + 32'(4 * r));
      tick();
      if (r != 0) nxt++;
    end
    // reset mid-stream wins over handshakes
    rst = 1'b1; #1;
    check("mid_rst_fw_ready", 32'(fw_ready), 32'd0);
    tick();
    check("mid_rst_valid", 32'(ir_valid), 32'd0);
    check("mid_rst_pc", ir_pc, 32'h60);
    rst = 1'b0; fw_valid = 1'b0; ir_ready = 1'b0; #1;
    // PC and expected address wrap at 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(); redirect = 1'b0;
    fw_valid = 1'b1; fw_addr = 32'hFFFF_FFFC; fw_data = 32'h4505_0000;
    tick(); fw_valid = 1'b0; #1;
    check("wrap_ir", ir, E_4505);
    check("wrap_pc", ir_pc, 32'hFFFF_FFFE);
    ir_ready = 1'b1; tick(); ir_ready = 1'b0; #1;
    check("wrap_pc0", ir_pc, 32'h0);
    fw_valid = 1'b1; fw_addr = 32'h0; fw_data = 32'h00A0_0093;
    tick(); fw_valid = 1'b0; #1;
    check("wrap_addr_valid", 32'(ir_valid), 32'd1);
    check("wrap_addr_ir", ir, 32'h00A0_0093);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
